iob_uart_tx_arb: RTL and testbench

- Round-robin, packet-locking arbiter that shares one uart_core transmit path between N_REQ byte-stream requesters (e.g. CPU CSR path, DMA, debug monitor).
- Sits between the requesters and the uart_core tx_data_i / data_write_en_i / tx_ready_o interface.
- Sequences one write per byte and paces writes against the core's registered tx_ready.
- Holds a grant until the requester's last byte, so packets from different requesters never interleave on txd.

---
 rtl/iob_uart_tx_arb_if.sv | 25 ++
 rtl/iob_uart_tx_arb.sv | 117 +++++++++++
 tb/tb_iob_uart_tx_arb.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_uart_tx_arb_if.sv
// iob_uart_tx_arb_if: requester byte streams and uart_core tx signals around iob_uart_tx_arb.
interface iob_uart_tx_arb_if #(
    parameter int N_REQ = 4,
    parameter int UART_DATA_W = 8
);
    logic tx_en_i;
    logic [N_REQ-1:0] req_valid_i;
    logic [N_REQ*UART_DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0] req_last_i;
    logic [N_REQ-1:0] req_ready_o;
    logic tx_ready_i;
    logic [UART_DATA_W-1:0] tx_data_o;
    logic tx_wen_o;
    logic [N_REQ-1:0] grant_o;
    logic busy_o;
    logic timeout_o;
    modport slave (
        input tx_en_i, req_valid_i, req_data_i, req_last_i, tx_ready_i,
        output req_ready_o, tx_data_o, tx_wen_o, grant_o, busy_o, timeout_o
    );
    modport master (
        output tx_en_i, req_valid_i, req_data_i, req_last_i, tx_ready_i,
        input req_ready_o, tx_data_o, tx_wen_o, grant_o, busy_o, timeout_o
    );
endinterface

// File: rtl/iob_uart_tx_arb.sv
// iob_uart_tx_arb: round-robin packet-locking arbiter sharing one uart_core tx path.
// Define IOB_UART_TX_ARB_TIMEOUT_EN to build the idle-lock release counter.
module iob_uart_tx_arb #(
    parameter int N_REQ = 4,
    parameter int UART_DATA_W = 8,
    parameter int TIMEOUT = 1024
) (
    input logic clk_i,
    input logic rst_i,
    iob_uart_tx_arb_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int PW1 = PTR_W + 1;
    localparam logic [PW1-1:0] NR = PW1'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("iob_uart_tx_arb: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, LOCK, SEND, GAP} state_t;

    state_t state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d, rot;
    logic [PTR_W-1:0] ptr_q, ptr_d, gidx_q, gidx_d, gnext;
    logic [PW1-1:0] off, sum, win;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic last_q, last_d, timeout_q, timeout_d, valid_g, hs, to_fire;

    // Rotate valids so bit 0 is the pointer position; lowest set bit wins.
    always_comb begin
        valid_g = bus.req_valid_i[gidx_q];
        hs = state_q == LOCK && bus.tx_en_i && bus.tx_ready_i && valid_g;
        gnext = gidx_q == LAST_IDX ? '0 : gidx_q + 1'b1;
        rot = N_REQ'({bus.req_valid_i, bus.req_valid_i} >> ptr_q);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) if (rot[k]) off = PW1'(k);
        sum = {1'b0, ptr_q} + off;
        win = sum >= NR ? sum - NR : sum;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d = ptr_q;
        gidx_d = gidx_q;
        data_d = data_q;
        last_d = last_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: if (bus.tx_en_i && |bus.req_valid_i) begin
                gidx_d = win[PTR_W-1:0];
                grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win[PTR_W-1:0];
                state_d = LOCK;
            end
            LOCK: if (hs) begin
                data_d = bus.req_data_i[gidx_q*UART_DATA_W +: UART_DATA_W];
                last_d = bus.req_last_i[gidx_q];
                state_d = SEND;
            end else if (to_fire) begin
                timeout_d = 1'b1;
                ptr_d = gnext;
                grant_d = '0;
                state_d = IDLE;
            end
            SEND: state_d = GAP;
            default: begin
                state_d = last_q ? IDLE : LOCK;
                ptr_d = last_q ? gnext : ptr_q;
                grant_d = last_q ? '0 : grant_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q <= '0;
            gidx_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q <= ptr_d;
            gidx_q <= gidx_d;
            data_q <= data_d;
            last_q <= last_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef IOB_UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
    // Counts starved LOCK cycles; fires on the cycle the count reaches TIMEOUT.
    always_comb begin
        to_fire = state_q == LOCK && !valid_g && cnt_q == TO_LAST;
        cnt_d = (state_q == LOCK && !valid_g && !to_fire) ? cnt_q + 16'd1 : '0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    assign to_fire = 1'b0;
`endif

    assign bus.req_ready_o = hs ? grant_q : '0;
    assign bus.tx_data_o = data_q;
    assign bus.tx_wen_o = state_q == SEND;
    assign bus.grant_o = grant_q;
    assign bus.busy_o = state_q != IDLE;
    assign bus.timeout_o = timeout_q;
endmodule

// File: tb/tb_iob_uart_tx_arb.sv
// tb_iob_uart_tx_arb: scoreboard bench; expected byte order comes from a round-robin packet model.
module tb_iob_uart_tx_arb;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct {logic [W-1:0] b; logic last; logic first;} ent_t;
    typedef struct {int id; logic [W-1:0] b;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_ptr = 0;
    bit rnd_mode = 0;
    bit drop_en = 0;
    ent_t st_q[N][$];
    ent_t drv_q[N][$];
    exp_t exp_q[$];
    int wen_cyc[$];

    iob_uart_tx_arb_if #(.N_REQ(N), .UART_DATA_W(W)) bus();

    iob_uart_tx_arb #(.N_REQ(N), .UART_DATA_W(W), .TIMEOUT(8)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_seq(input int r, input int len, input int b0 = -1, input bit term = 1);
        ent_t e;
        for (int i = 0; i < len; i++) begin
            e.b = (b0 < 0) ? W'($urandom) : W'(b0 + i);
            e.first = (i == 0);
            e.last = term && (i == len - 1);
            st_q[r].push_back(e);
        end
    endtask

    // Reference: serve whole packets, first non-empty requester from the pointer upward.
    task automatic commit();
        ent_t t[N][$];
        ent_t e;
        exp_t x;
        int ptr, r;
        bit done;
        ptr = m_ptr;
        for (int i = 0; i < N; i++) t[i] = st_q[i];
        while (1) begin
            r = -1;
            for (int k = N - 1; k >= 0; k--) if (t[(ptr + k) % N].size() > 0) r = (ptr + k) % N;
            if (r < 0) break;
            done = 0;
            while (!done) begin
                e = t[r].pop_front();
                x.id = r;
                x.b = e.b;
                exp_q.push_back(x);
                done = e.last || t[r].size() == 0;
            end
            ptr = (r + 1) % N;
        end
        m_ptr = ptr;
        for (int i = 0; i < N; i++) begin
            foreach (st_q[i][j]) drv_q[i].push_back(st_q[i][j]);
            st_q[i].delete();
        end
    endtask

    function automatic int pending();
        int s;
        s = exp_q.size();
        for (int r = 0; r < N; r++) s += drv_q[r].size();
        return s;
    endfunction

    task automatic do_reset(input bit now);
        if (!now) @(negedge clk);
        #2;
        rst = 1'b1;
        for (int r = 0; r < N; r++) begin
            drv_q[r].delete();
            st_q[r].delete();
        end
        exp_q.delete();
        m_ptr = 0;
        @(negedge clk);
        check("rst_grant", bus.grant_o, 0);
        check("rst_wen", bus.tx_wen_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_data", bus.tx_data_o, 0);
        check("rst_ready", bus.req_ready_o, 0);
        check("rst_timeout", bus.timeout_o, 0);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((pending() != 0 || bus.busy_o) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, pending(), 0);
        check({name, "_idle"}, bus.busy_o, 0);
    endtask

    // Requester driver: pops accepted bytes, presents the next one, optionally bubbles mid-packet.
    initial begin
        logic [N-1:0] acc;
        bit dropped[N];
        forever begin
            @(negedge clk);
            acc = bus.req_ready_o;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                dropped[i] = drop_en && !dropped[i] && drv_q[i].size() > 0 && !drv_q[i][0].first
                             && $urandom_range(0, 3) == 0;
                bus.req_valid_i[i] = drv_q[i].size() > 0 && !dropped[i];
                bus.req_data_i[i*W +: W] = drv_q[i].size() > 0 ? drv_q[i][0].b : '0;
                bus.req_last_i[i] = drv_q[i].size() > 0 && drv_q[i][0].last;
            end
            if (rnd_mode) begin
                bus.tx_ready_i = $urandom_range(0, 2) != 0;
                bus.tx_en_i = $urandom_range(0, 7) != 0;
            end
        end
    end

    // Monitor: every write strobe must match the head of the expected queue.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            check("grant_onehot0", $onehot0(bus.grant_o), 1);
            if (bus.tx_wen_o) begin
                wen_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wen: got data 0x%0h grant 0x%0h with nothing outstanding",
                             bus.tx_data_o, bus.grant_o);
                end else begin
                    x = exp_q.pop_front();
                    check("wen_grant", bus.grant_o, 1 << x.id);
                    check("wen_data", bus.tx_data_o, x.b);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        bit any;
        bus.tx_en_i = 1'b1;
        bus.tx_ready_i = 1'b1;
        bus.req_valid_i = '0;
        bus.req_data_i = '0;
        bus.req_last_i = '0;
        do_reset(0);

        @(negedge clk);
        wen_cyc.delete();
        add_seq(2, 2, 'h41);
        commit();
        @(negedge clk);
        check("t1_grant_before", bus.grant_o, 0);
        @(negedge clk);
        check("t1_grant", bus.grant_o, 4'b0100);
        wait_idle("t1", 50);
        check("t1_wen_count", wen_cyc.size(), 2);
        if (wen_cyc.size() == 2) check("t1_wen_gap", wen_cyc[1] - wen_cyc[0], 3);

        do_reset(0);
        @(negedge clk);
        add_seq(0, 2);
        add_seq(1, 2);
        add_seq(3, 2);
        add_seq(0, 2);
        commit();
        wait_idle("t2", 200);

        @(negedge clk);
        bus.tx_ready_i = 1'b0;
        add_seq(1, 1);
        commit();
        n = 0;
        while (bus.grant_o == 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t3_grant", bus.grant_o, 4'b0010);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.req_ready_o != 0 || bus.tx_wen_o) bad++;
        end
        check("t3_stall", bad, 0);
        @(posedge clk);
        #2;
        bus.tx_ready_i = 1'b1;
        #1;
        check("t3_accept", bus.req_ready_o, 4'b0010);
        wait_idle("t3", 50);

        @(negedge clk);
        add_seq(0, 3);
        commit();
        n = 0;
        while (!bus.tx_wen_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_in_send", bus.tx_wen_o, 1);
        do_reset(1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.tx_wen_o || bus.busy_o) bad++;
        end
        check("t4_no_wen", bad, 0);

        @(negedge clk);
        bus.tx_en_i = 1'b0;
        add_seq(1, 1);
        commit();
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.grant_o != 0) bad++;
        end
        check("t5_blocked", bad, 0);
        bus.tx_en_i = 1'b1;
        @(negedge clk);
        check("t5_grant", bus.grant_o, 4'b0010);
        wait_idle("t5", 50);

        do_reset(0);
        @(negedge clk);
        add_seq(0, 1, 'h55, 0);
        add_seq(2, 1, 'h66);
        commit();
        n = 0;
        while (!bus.tx_wen_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_first_byte", bus.tx_wen_o, 1);
        bad = 0;
        repeat (9) begin
            @(negedge clk);
            if (bus.timeout_o) bad++;
        end
        check("t6_no_early_timeout", bad, 0);
        @(negedge clk);
`ifdef IOB_UART_TX_ARB_TIMEOUT_EN
        check("t6_timeout", bus.timeout_o, 1);
        check("t6_grant_clear", bus.grant_o, 0);
        @(negedge clk);
        check("t6_timeout_pulse", bus.timeout_o, 0);
        check("t6_regrant", bus.grant_o, 4'b0100);
        wait_idle("t6", 50);
`else
        check("t6_timeout", bus.timeout_o, 0);
        check("t6_grant_hold", bus.grant_o, 4'b0001);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.timeout_o || bus.grant_o != 4'b0001) bad++;
        end
        check("t6_lock_held", bad, 0);
`endif

        do_reset(0);
        drop_en = 1;
        rnd_mode = 1;
        for (int b = 0; b < 12; b++) begin
            @(negedge clk);
            any = 0;
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    any = 1;
                    repeat ($urandom_range(1, 2)) add_seq(r, $urandom_range(1, 4));
                end
            end
            if (!any) add_seq($urandom_range(0, N - 1), $urandom_range(1, 4));
            commit();
            wait_idle("rnd", 600);
        end
        rnd_mode = 0;
        drop_en = 0;
        @(posedge clk);
        #2;
        bus.tx_en_i = 1'b1;
        bus.tx_ready_i = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
